// File: rtl/rms_pkg.sv
// Shared types and default parameters for the register management system
// and its context-save engine.
package rms_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAVE    = 2'd1,
        ST_RESTORE = 2'd2
    } ctx_state_e;

    typedef enum logic [1:0] {
        RS_IMM  = 2'd0,
        RS_W2A  = 2'd1,
        RS_W2B  = 2'd2,
        RS_MOVE = 2'd3
    } regsrc_e;

    localparam int DEF_DW          = 16;
    localparam int DEF_NREGS       = 64;
    localparam int DEF_CR_ADDR     = 57;
    localparam int DEF_IO_IN_ADDR  = 62;
    localparam int DEF_IO_OUT_ADDR = 63;
    localparam int DEF_SAVE_BASE   = 42;
    localparam int DEF_NSAVE       = 15;
    localparam int DEF_DEPTH       = 4;

endpackage

// File: rtl/rms_ctx_if.sv
// Decode-side bundle of rms_ctx: instruction, write sources, controls,
// context requests and the operand/status outputs.
interface rms_ctx_if #(
    parameter int DW = 16
);
    logic [DW-1:0] ir;
    logic [DW-1:0] imm_r;
    logic [DW-1:0] w2_a;
    logic [DW-1:0] w2_b;
    logic          alt_b;
    logic          write_cr;
    logic          reg_r1;
    logic          reg_r2;
    logic          reg_w1;
    logic          reg_w2;
    logic [1:0]    regsrc;
    logic          cmpeq;
    logic          cmpne;
    logic          save_req;
    logic          restore_req;
    logic [DW-1:0] io_in;
    logic [3:0]    op;
    logic [DW-1:0] immediate;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          cmp_result;
    logic [DW-1:0] io_out;
    logic          busy;
    logic          ctx_ovf;
    logic          ctx_unf;

    modport master (
        output ir, imm_r, w2_a, w2_b, alt_b, write_cr, reg_r1, reg_r2,
               reg_w1, reg_w2, regsrc, cmpeq, cmpne, save_req, restore_req, io_in,
        input  op, immediate, a, b, cmp_result, io_out, busy, ctx_ovf, ctx_unf
    );

    modport slave (
        input  ir, imm_r, w2_a, w2_b, alt_b, write_cr, reg_r1, reg_r2,
               reg_w1, reg_w2, regsrc, cmpeq, cmpne, save_req, restore_req, io_in,
        output op, immediate, a, b, cmp_result, io_out, busy, ctx_ovf, ctx_unf
    );
endinterface

// File: rtl/rms_frame_stack.sv
// Frame storage for saved register windows: one memory per stack level,
// the stack pointer and the sticky overflow/underflow flags.
module rms_frame_stack
    import rms_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int NSAVE = DEF_NSAVE,
    parameter int DEPTH = DEF_DEPTH,
    parameter int IW    = (NSAVE > 1) ? $clog2(NSAVE) : 1,
    parameter int SPW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          save_try,
    input  logic          restore_try,
    input  logic          commit_save,
    input  logic          wr_en,
    input  logic [IW-1:0] idx,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] rd_data,
    output logic          save_ok,
    output logic          restore_ok,
    output logic          ctx_ovf,
    output logic          ctx_unf
);
    localparam int FW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [SPW-1:0] sp_reg;
    logic [DW-1:0]  frame_word [DEPTH];
    logic           ovf_reg;
    logic           unf_reg;

    assign save_ok    = (sp_reg != SPW'(DEPTH));
    assign restore_ok = (sp_reg != '0);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_frame
            logic [DW-1:0] mem [NSAVE];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < NSAVE; i++) mem[i] <= '0;
                end else if (wr_en && sp_reg == SPW'(gi)) begin
                    mem[idx] <= wr_data;
                end
            end

            assign frame_word[gi] = mem[idx];
        end
    endgenerate

    // During a restore sp already points at the frame being copied back.
    assign rd_data = frame_word[sp_reg[FW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_reg  <= '0;
            ovf_reg <= 1'b0;
            unf_reg <= 1'b0;
        end else begin
            if (commit_save)
                sp_reg <= sp_reg + 1'b1;
            else if (restore_try && restore_ok)
                sp_reg <= sp_reg - 1'b1;
            if (save_try && !save_ok)
                ovf_reg <= 1'b1;
            if (restore_try && !restore_ok)
                unf_reg <= 1'b1;
        end
    end

    assign ctx_ovf = ovf_reg;
    assign ctx_unf = unf_reg;
endmodule

// File: rtl/rms_ctx.sv
// Register file with registered A/B operands, IR field decode, comparator,
// I/O register, and a sequential engine that saves/restores a register window.
module rms_ctx
    import rms_pkg::*;
#(
    parameter int DW          = DEF_DW,
    parameter int NREGS       = DEF_NREGS,
    parameter int CR_ADDR     = DEF_CR_ADDR,
    parameter int IO_IN_ADDR  = DEF_IO_IN_ADDR,
    parameter int IO_OUT_ADDR = DEF_IO_OUT_ADDR,
    parameter int SAVE_BASE   = DEF_SAVE_BASE,
    parameter int NSAVE       = DEF_NSAVE,
    parameter int DEPTH       = DEF_DEPTH
) (
    input  logic       clk,
    input  logic       rst_n,
    rms_ctx_if.slave   bus
);
    localparam int AW  = $clog2(NREGS);
    localparam int IW  = (NSAVE > 1) ? $clog2(NSAVE) : 1;
    localparam int SPW = $clog2(DEPTH + 1);

    logic [DW-1:0] regs [NREGS];
    logic [DW-1:0] a_reg, b_reg;
    ctx_state_e    state_reg, state_next;
    logic [IW-1:0] idx_reg, idx_next;

    logic [AW-1:0] addr1, addr2, win_addr;
    logic [DW-1:0] rd1_data, rd2_data, wr2_data, frame_rd;
    logic          busy, p1_we, p2_we, win_wr;
    logic          save_try, restore_try, save_ok, restore_ok;
    logic          frame_wr, commit_save;

    assign busy     = (state_reg != ST_IDLE);
    assign addr1    = bus.write_cr ? AW'(CR_ADDR) : bus.ir[2*AW-1:AW];
    assign addr2    = bus.ir[AW-1:0];
    assign win_addr = AW'(SAVE_BASE) + AW'(idx_reg);

    assign rd1_data = (addr1 == AW'(IO_IN_ADDR)) ? bus.io_in : regs[addr1];
    assign rd2_data = (addr2 == AW'(IO_IN_ADDR)) ? bus.io_in : regs[addr2];

    always_comb begin
        wr2_data = a_reg;
        case (regsrc_e'(bus.regsrc))
            RS_IMM:  wr2_data = bus.imm_r;
            RS_W2A:  wr2_data = bus.w2_a;
            RS_W2B:  wr2_data = bus.w2_b;
            RS_MOVE: wr2_data = a_reg;
            default: wr2_data = a_reg;
        endcase
    end

    // The input-port address has no storage behind it, so writes to it vanish.
    assign p1_we  = !busy && bus.reg_w1 && (addr1 != AW'(IO_IN_ADDR));
    assign p2_we  = !busy && bus.reg_w2 && (addr2 != AW'(IO_IN_ADDR));
    assign win_wr = (state_reg == ST_RESTORE) && (win_addr != AW'(IO_IN_ADDR));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            if (win_wr)
                regs[win_addr] <= frame_rd;
            if (p1_we)
                regs[addr1] <= {{(DW-1){1'b0}}, bus.alt_b};
            // Port 2 is written last so it wins an address collision.
            if (p2_we)
                regs[addr2] <= wr2_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
        end else if (!busy) begin
            if (bus.reg_r1) a_reg <= rd1_data;
            if (bus.reg_r2) b_reg <= rd2_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        save_try    = 1'b0;
        restore_try = 1'b0;
        frame_wr    = 1'b0;
        commit_save = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.save_req) begin
                    save_try = 1'b1;
                    if (save_ok) begin
                        idx_next   = '0;
                        state_next = ST_SAVE;
                    end
                end else if (bus.restore_req) begin
                    restore_try = 1'b1;
                    if (restore_ok) begin
                        idx_next   = '0;
                        state_next = ST_RESTORE;
                    end
                end
            end
            ST_SAVE: begin
                frame_wr = 1'b1;
                if (idx_reg == IW'(NSAVE - 1)) begin
                    commit_save = 1'b1;
                    idx_next    = '0;
                    state_next  = ST_IDLE;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            ST_RESTORE: begin
                if (idx_reg == IW'(NSAVE - 1)) begin
                    idx_next   = '0;
                    state_next = ST_IDLE;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                idx_next   = '0;
            end
        endcase
    end

    rms_frame_stack #(
        .DW    (DW),
        .NSAVE (NSAVE),
        .DEPTH (DEPTH),
        .IW    (IW),
        .SPW   (SPW)
    ) u_frame_stack (
        .clk         (clk),
        .rst_n       (rst_n),
        .save_try    (save_try),
        .restore_try (restore_try),
        .commit_save (commit_save),
        .wr_en       (frame_wr),
        .idx         (idx_reg),
        .wr_data     (regs[win_addr]),
        .rd_data     (frame_rd),
        .save_ok     (save_ok),
        .restore_ok  (restore_ok),
        .ctx_ovf     (bus.ctx_ovf),
        .ctx_unf     (bus.ctx_unf)
    );

    assign bus.op         = bus.ir[DW-1:DW-4];
    assign bus.immediate  = {{(DW-2*AW){bus.ir[2*AW-1]}}, bus.ir[2*AW-1:0]};
    assign bus.a          = a_reg;
    assign bus.b          = b_reg;
    assign bus.cmp_result = (bus.cmpeq && (a_reg == b_reg)) || (bus.cmpne && (a_reg != b_reg));
    assign bus.io_out     = regs[IO_OUT_ADDR];
    assign bus.busy       = busy;
endmodule

// File: tb/tb_rms_ctx.sv
// Scoreboard bench for rms_ctx: stimulus queues expected values, a negedge
// monitor pops and compares them against the DUT outputs.
module tb_rms_ctx;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rms_ctx_if #(.DW(16)) bus();

    rms_ctx dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef enum int {F_A, F_B, F_CMP, F_IO, F_BUSY, F_OVF, F_UNF, F_OP, F_IMM} field_e;
    typedef struct {
        field_e      f;
        logic [15:0] v;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [15:0] actual(field_e f);
        case (f)
            F_A:    return bus.a;
            F_B:    return bus.b;
            F_CMP:  return {15'd0, bus.cmp_result};
            F_IO:   return bus.io_out;
            F_BUSY: return {15'd0, bus.busy};
            F_OVF:  return {15'd0, bus.ctx_ovf};
            F_UNF:  return {15'd0, bus.ctx_unf};
            F_OP:   return {12'd0, bus.op};
            F_IMM:  return bus.immediate;
            default: return 16'hxxxx;
        endcase
    endfunction

    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            exp_t e;
            logic [15:0] got;
            e = sb_q.pop_front();
            got = actual(e.f);
            n_cmp++;
            if (got !== e.v) begin
                n_bad++;
                $display("FAIL %s: got 0x%04h expected 0x%04h", e.name, got, e.v);
            end else begin
                $display("ok   %s: 0x%04h", e.name, got);
            end
        end
    end

    task automatic expect_val(input field_e f, input logic [15:0] v, input string name);
        exp_t e;
        e.f = f;
        e.v = v;
        e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [15:0] mk_ir(input logic [3:0] op, input logic [5:0] fa, input logic [5:0] fb);
        return {op, fa, fb};
    endfunction

    task automatic idle();
        bus.ir = '0; bus.imm_r = '0; bus.w2_a = '0; bus.w2_b = '0;
        bus.alt_b = 1'b0; bus.write_cr = 1'b0;
        bus.reg_r1 = 1'b0; bus.reg_r2 = 1'b0; bus.reg_w1 = 1'b0; bus.reg_w2 = 1'b0;
        bus.regsrc = 2'd0; bus.cmpeq = 1'b0; bus.cmpne = 1'b0;
        bus.save_req = 1'b0; bus.restore_req = 1'b0;
    endtask

    // Selected source carries d; the other two carry a decoy value.
    task automatic wr2(input logic [5:0] ad, input logic [1:0] src, input logic [15:0] d);
        bus.ir = mk_ir(4'd0, 6'd0, ad);
        bus.regsrc = src;
        bus.imm_r = (src == 2'd0) ? d : 16'hFFFF;
        bus.w2_a  = (src == 2'd1) ? d : 16'hFFFF;
        bus.w2_b  = (src == 2'd2) ? d : 16'hFFFF;
        bus.reg_w2 = 1'b1;
        tick();
        bus.reg_w2 = 1'b0;
    endtask

    task automatic rd(input logic [5:0] fa, input logic [5:0] fb);
        bus.ir = mk_ir(4'd0, fa, fb);
        bus.reg_r1 = 1'b1;
        bus.reg_r2 = 1'b1;
        tick();
        bus.reg_r1 = 1'b0;
        bus.reg_r2 = 1'b0;
    endtask

    // Call right after the accepting edge: busy for 15 cycles, then low.
    task automatic busy_window(input string nm);
        expect_val(F_BUSY, 16'd1, nm);
        for (int k = 1; k < 15; k++) begin
            tick();
            expect_val(F_BUSY, 16'd1, nm);
        end
        tick();
        expect_val(F_BUSY, 16'd0, {nm, "_end"});
    endtask

    task automatic do_save(input string nm);
        bus.save_req = 1'b1;
        tick();
        bus.save_req = 1'b0;
        busy_window(nm);
    endtask

    task automatic do_restore(input string nm);
        bus.restore_req = 1'b1;
        tick();
        bus.restore_req = 1'b0;
        busy_window(nm);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        bus.io_in = '0;
        #1;
        expect_val(F_A, 16'h0000, "rst_a");
        expect_val(F_B, 16'h0000, "rst_b");
        expect_val(F_IO, 16'h0000, "rst_io_out");
        expect_val(F_BUSY, 16'd0, "rst_busy");
        expect_val(F_OVF, 16'd0, "rst_ovf");
        expect_val(F_UNF, 16'd0, "rst_unf");
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Immediate write then dual read, comparator both modes.
        wr2(6'd5, 2'd0, 16'h1234);
        rd(6'd5, 6'd5);
        expect_val(F_A, 16'h1234, "rd_a_r5");
        expect_val(F_B, 16'h1234, "rd_b_r5");
        bus.cmpeq = 1'b1;
        expect_val(F_CMP, 16'd1, "cmpeq_equal");
        settle();
        bus.cmpeq = 1'b0;
        bus.cmpne = 1'b1;
        expect_val(F_CMP, 16'd0, "cmpne_equal");
        settle();
        bus.cmpne = 1'b0;
        expect_val(F_CMP, 16'd0, "cmp_disabled");
        settle();

        // Field decode.
        bus.ir = 16'hAF85;
        expect_val(F_OP, 16'h000A, "op_A");
        expect_val(F_IMM, 16'hFF85, "imm_neg");
        settle();
        bus.ir = 16'h307F;
        expect_val(F_OP, 16'h0003, "op_3");
        expect_val(F_IMM, 16'h007F, "imm_pos");
        settle();

        // Same-edge write and read of R5 returns the old value.
        bus.ir = mk_ir(4'd0, 6'd0, 6'd5);
        bus.regsrc = 2'd0; bus.imm_r = 16'h5555;
        bus.reg_w2 = 1'b1; bus.reg_r2 = 1'b1;
        tick();
        bus.reg_w2 = 1'b0; bus.reg_r2 = 1'b0;
        expect_val(F_B, 16'h1234, "no_write_through");
        rd(6'd0, 6'd5);
        expect_val(F_A, 16'h0000, "rd_a_r0");
        expect_val(F_B, 16'h5555, "rd_b_r5_new");
        bus.cmpne = 1'b1;
        expect_val(F_CMP, 16'd1, "cmpne_differ");
        settle();
        bus.cmpne = 1'b0;

        // Move: R7 gets the pre-edge A while A is reloaded the same edge.
        rd(6'd5, 6'd0);
        expect_val(F_A, 16'h5555, "a_before_move");
        bus.ir = mk_ir(4'd0, 6'd0, 6'd7);
        bus.regsrc = 2'd3; bus.reg_w2 = 1'b1; bus.reg_r1 = 1'b1;
        tick();
        bus.reg_w2 = 1'b0; bus.reg_r1 = 1'b0;
        expect_val(F_A, 16'h0000, "a_reload_r0");
        rd(6'd7, 6'd0);
        expect_val(F_A, 16'h5555, "move_r7");

        // Control register port, then port-2 wins a collision on it.
        bus.write_cr = 1'b1; bus.alt_b = 1'b1; bus.reg_w1 = 1'b1;
        bus.ir = mk_ir(4'd0, 6'd3, 6'd0);
        tick();
        bus.reg_w1 = 1'b0;
        bus.reg_r1 = 1'b1;
        tick();
        bus.reg_r1 = 1'b0;
        expect_val(F_A, 16'h0001, "cr_alt_b");
        bus.reg_w1 = 1'b1; bus.reg_w2 = 1'b1; bus.regsrc = 2'd1;
        bus.w2_a = 16'hBEEF; bus.ir = mk_ir(4'd0, 6'd3, 6'd57);
        tick();
        bus.reg_w1 = 1'b0; bus.reg_w2 = 1'b0;
        bus.reg_r1 = 1'b1; bus.reg_r2 = 1'b1;
        tick();
        bus.reg_r1 = 1'b0; bus.reg_r2 = 1'b0;
        bus.write_cr = 1'b0; bus.alt_b = 1'b0;
        expect_val(F_A, 16'hBEEF, "cr_collision_a");
        expect_val(F_B, 16'hBEEF, "cr_collision_b");
        wr2(6'd8, 2'd2, 16'h7E57);
        rd(6'd3, 6'd8);
        expect_val(F_A, 16'h0000, "r3_untouched");
        expect_val(F_B, 16'h7E57, "regsrc_w2b");

        // I/O registers.
        expect_val(F_IO, 16'h0000, "io_out_before");
        wr2(6'd63, 2'd0, 16'hA5A5);
        expect_val(F_IO, 16'hA5A5, "io_out_write");
        bus.io_in = 16'h0F0F;
        bus.ir = mk_ir(4'd0, 6'd62, 6'd0);
        bus.reg_r1 = 1'b1;
        tick();
        bus.reg_r1 = 1'b0;
        expect_val(F_A, 16'h0F0F, "io_in_read");

        // Fill window, save with writes attempted while busy.
        for (int i = 0; i < 15; i++) wr2(6'(42 + i), 2'd0, 16'h0100 + 16'(i));
        bus.save_req = 1'b1;
        tick();
        bus.save_req = 1'b0;
        expect_val(F_BUSY, 16'd1, "save_busy");
        tick();
        expect_val(F_BUSY, 16'd1, "save_busy");
        bus.ir = mk_ir(4'd0, 6'd5, 6'd5);
        bus.regsrc = 2'd0; bus.imm_r = 16'hDEAD;
        bus.reg_w2 = 1'b1; bus.reg_r1 = 1'b1;
        tick();
        bus.reg_w2 = 1'b0; bus.reg_r1 = 1'b0;
        expect_val(F_BUSY, 16'd1, "save_busy");
        expect_val(F_A, 16'h0F0F, "a_holds_busy");
        for (int k = 3; k < 15; k++) begin
            tick();
            expect_val(F_BUSY, 16'd1, "save_busy");
        end
        tick();
        expect_val(F_BUSY, 16'd0, "save_busy_end");

        for (int i = 0; i < 15; i++) wr2(6'(42 + i), 2'd0, 16'h0000);
        rd(6'd42, 6'd56);
        expect_val(F_A, 16'h0000, "win_cleared_lo");
        expect_val(F_B, 16'h0000, "win_cleared_hi");
        do_restore("restore_busy");
        for (int i = 0; i < 15; i++) begin
            rd(6'(42 + i), 6'd0);
            expect_val(F_A, 16'h0100 + 16'(i), $sformatf("restored_r%0d", 42 + i));
        end
        rd(6'd5, 6'd0);
        expect_val(F_A, 16'h5555, "busy_write_dropped");

        // Fill stack; a fifth save (with a competing restore) overflows.
        for (int n = 0; n < 4; n++) do_save($sformatf("fill_save%0d", n));
        expect_val(F_OVF, 16'd0, "ovf_at_depth");
        bus.save_req = 1'b1; bus.restore_req = 1'b1;
        tick();
        bus.save_req = 1'b0; bus.restore_req = 1'b0;
        expect_val(F_OVF, 16'd1, "ovf_set");
        expect_val(F_BUSY, 16'd0, "ovf_no_busy");
        for (int n = 0; n < 4; n++) do_restore($sformatf("drain_restore%0d", n));
        expect_val(F_UNF, 16'd0, "unf_after_drain");
        bus.restore_req = 1'b1;
        tick();
        bus.restore_req = 1'b0;
        expect_val(F_UNF, 16'd1, "unf_set_empty");
        expect_val(F_BUSY, 16'd0, "unf_no_busy");
        expect_val(F_OVF, 16'd1, "ovf_sticky");

        // Reset five cycles into a save.
        bus.save_req = 1'b1;
        tick();
        bus.save_req = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        expect_val(F_BUSY, 16'd1, "mid_save_busy");
        settle();
        rst_n = 1'b0;
        #1;
        expect_val(F_BUSY, 16'd0, "abort_busy");
        expect_val(F_A, 16'h0000, "abort_a");
        expect_val(F_B, 16'h0000, "abort_b");
        expect_val(F_IO, 16'h0000, "abort_io_out");
        expect_val(F_OVF, 16'd0, "abort_ovf");
        expect_val(F_UNF, 16'd0, "abort_unf");
        tick(); tick();
        rst_n = 1'b1;
        tick();
        rd(6'd42, 6'd5);
        expect_val(F_A, 16'h0000, "abort_r42_cleared");
        expect_val(F_B, 16'h0000, "abort_r5_cleared");
        bus.restore_req = 1'b1;
        tick();
        bus.restore_req = 1'b0;
        expect_val(F_UNF, 16'd1, "unf_after_reset");
        expect_val(F_BUSY, 16'd0, "unf_after_reset_busy");

        settle();
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0 pending", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
